regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

- Shares the register file's single write port among three writers: ALU writeback, MOV immediate load and memory load.
- Buffers each writer's requests in a small FIFO.
- Grants the write port round-robin, one write per cycle, and drives the register file's `WriteEn`/`Waddr`/`DataIn` from a registered output stage.
- Keeps a per-register pending-write scoreboard so decode can stall reads of registers with writes still in flight.

## Interface

Parameters:
- `W`, 8: data width.
- `D`, 3: register address width (2**D registers).
- `N`, 3: number of requesters. Fixed indices: 0 = ALU, 1 = MOV, 2 = memory load.
- `DEPTH`, 2: per-requester FIFO depth; must be a power of 2, ≥ 2.

Ports:
- `Clk`  in  1: single clock; all state updates on its rising edge.
- `Reset`  in  1: asynchronous, active-low; low clears all state immediately.
- `ReqValid`  in  N: per-requester write request.
- `ReqAddr`  in  N×D: per-requester destination register.
- `ReqData`  in  N×W: per-requester write data.
- `ReqReady`  out  N: FIFO i not full; reset value all 1.
- `WriteEn`  out  1: register-file write enable; reset value 0.
- `Waddr`  out  D: register-file write address; reset value 0.
- `WData`  out  W: register-file write data; reset value 0.
- `Busy`  out  2**D: bit a = one or more writes to register a pending; reset value 0.
- `Idle`  out  1: all FIFOs empty and `WriteEn`=0; reset value 1.

## Operation

- **Accept:** request i is accepted at a rising edge when `ReqValid[i]` && `ReqReady[i]`. {addr, data} is pushed into FIFO i. Per-requester order is preserved.
- **ReqReady:** `ReqReady[i]` is combinational from FIFO i's count only (count < `DEPTH`). It does not depend on `ReqValid`.
- **Arbitration:** each cycle, the eligible set is the non-empty FIFOs.
  - Round-robin pointer `Last` (reset N-1): the grant goes to the first eligible index after `Last`, wrapping modulo N.
  - On a grant, the head is popped and `Last` is set to the granted index.
  - With no eligible FIFO, `Last` is held.
- **Output stage:** the grant's {addr, data} is registered into `Waddr`/`WData` with `WriteEn`=1.
  - With no grant, `WriteEn`=0 and `Waddr`/`WData` hold their values.
  - The output stage never stalls: the register file always accepts a write.
- **Scoreboard:** one counter per register, width clog2(N×DEPTH+2).
  - Increment on accept to that address.
  - Decrement at the edge ending a cycle with `WriteEn`=1 and `Waddr` = that address.
  - Multiple accepts to the same address in one cycle add their count.
  - Simultaneous increment and decrement on the same address cancel.
  - `Busy[a]` = counter a ≠ 0.
  - A counter reaching 0 or its maximum must not wrap. The latter is unreachable by construction; an assertion guards it.
- **Ordering:** writes to the same register from different requesters commit in arbitration order, not arrival order. Requesters needing ordering check `Busy` before issuing.
- **Full FIFO:** `ReqValid` while `ReqReady`=0 is ignored; no state change.
- **Push and pop on a full FIFO in the same cycle:** not allowed. `ReqReady` is already 0, so the push is refused even though a pop frees space that cycle.
- **Reset mid-operation:** buffered and in-flight writes are discarded. The write in the output stage is dropped: `WriteEn` falls asynchronously.

## Timing

- **Minimum latency:**
  - Request accepted at edge k.
  - Granted combinationally in cycle k+1.
  - `WriteEn`/`Waddr`/`WData` valid after edge k+1.
  - Register file written at edge k+2.
- **Busy timing:** `Busy[a]` rises after edge k (the accept edge) and falls after edge k+2 (the commit edge).
- **Throughput:** one write per cycle total. Each requester is served at least once every N cycles while non-empty.
- **Reset exit:** first accept possible at the first rising edge after `Reset` deasserts.

## Structure

- **Package `regfile_pkg`:** holds `W`, `D`, `N`, `DEPTH` defaults, the requester index constants `REQ_ALU`, `REQ_MOV`, `REQ_MEM`, and a `wr_req_t` struct {addr[D], data[W]}.
- **Sub-module `wr_fifo`:** parameterised width/depth; ports push/pop/full/empty/head. Instantiated N times.
- **In the top module:** the arbiter, output register and scoreboard.

## Test plan

1. **Reset values:** assert `Reset`=0 mid-traffic → `WriteEn`=0, `Busy`=0, `ReqReady`=3'b111 and `Idle`=1, all immediately and without a clock edge.
2. **Single write:** ALU writes addr 5, data 8'h36 at edge 0 → `Busy[5]`=1 after edge 0; `WriteEn`=1, `Waddr`=5, `WData`=8'h36 after edge 1; `Busy[5]`=0 and `Idle`=1 after edge 2.
3. **Round-robin:** all three requesters present one request each in the same cycle (addrs 1, 0, 2) → commits occur on consecutive cycles in order ALU, MOV, MEM. A second simultaneous round after MEM was granted starts again with ALU.
4. **Full FIFO:** hold `ReqValid[2]` with distinct data while MEM is never granted (ALU and MOV saturate the port) → `ReqReady[2]`=0 after 2 accepts. Further data is not pushed, and the 2 stored items later commit in order.
5. **Scoreboard counting:** ALU and MEM both write addr 3 in the same cycle → counter 3 = 2. `Busy[3]` stays 1 through the first commit and clears only after the second.
6. **Back-to-back:** one requester streams 8 writes (addr i, data 8'h40+i) with `ReqValid` held high → all 8 commit in order with no gaps after the first. `Busy` never sticks.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing, requester indices and write-request payload for the register-file write path.
package regfile_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned D     = 3;
    localparam int unsigned N     = 3;
    localparam int unsigned DEPTH = 2;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MOV = 1;
    localparam int unsigned REQ_MEM = 2;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// Small power-of-two FIFO buffering one requester's pending register writes.
module wr_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of three writers onto the register-file write port,
// with a registered output stage and a per-register pending-write scoreboard.
module regfile_write_arbiter #(
    parameter int unsigned W     = regfile_pkg::W,
    parameter int unsigned D     = regfile_pkg::D,
    parameter int unsigned N     = regfile_pkg::N,
    parameter int unsigned DEPTH = regfile_pkg::DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N-1:0]      ReqValid,
    input  logic [N*D-1:0]    ReqAddr,
    input  logic [N*W-1:0]    ReqData,
    output logic [N-1:0]      ReqReady,
    output logic              WriteEn,
    output logic [D-1:0]      Waddr,
    output logic [W-1:0]      WData,
    output logic [2**D-1:0]   Busy,
    output logic              Idle
);

    import regfile_pkg::*;

    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NREG = 2**D;
    localparam int unsigned CMAX = N*DEPTH + 1;
    localparam int unsigned CW   = $clog2(N*DEPTH + 2);
    localparam logic [IW-1:0] LAST_RST = IW'(REQ_MEM);

    logic [N-1:0]   full;
    logic [N-1:0]   empty;
    logic [N-1:0]   accept;
    logic [N-1:0]   pop;
    wr_req_t        push_req [N];
    wr_req_t        head     [N];

    logic [IW-1:0]  last;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_valid;
    wr_req_t        gnt_req;

    logic [CW-1:0]  cnt_q   [NREG];
    logic [CW-1:0]  cnt_d   [NREG];
    int unsigned    sb_sum  [NREG];

    // Per-requester buffers; payload layout follows regfile_pkg widths.
    for (genvar i = 0; i < N; i++) begin : g_req
        assign accept[i]        = ReqValid[i] & ~full[i];
        assign push_req[i].addr = ReqAddr[i*D +: D];
        assign push_req[i].data = ReqData[i*W +: W];
        assign pop[i]           = gnt_valid && (gnt_idx == IW'(i));

        wr_fifo #(
            .WIDTH ($bits(wr_req_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .Clk       (Clk),
            .Reset     (Reset),
            .push      (accept[i]),
            .push_data (push_req[i]),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    assign ReqReady = ~full;
    assign Idle     = (&empty) & ~WriteEn;

    // First non-empty index after last, scanned farthest-first so the nearest wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        for (int unsigned k = N; k >= 1; k--) begin
            if (!empty[IW'((32'(last) + k) % N)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'((32'(last) + k) % N);
            end
        end
    end

    assign gnt_req = head[gnt_idx];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WriteEn <= 1'b0;
            Waddr   <= '0;
            WData   <= '0;
            last    <= LAST_RST;
        end else begin
            WriteEn <= gnt_valid;
            if (gnt_valid) begin
                Waddr <= gnt_req.addr;
                WData <= gnt_req.data;
                last  <= gnt_idx;
            end
        end
    end

    // Pending-write counters: accepts add, the committing write subtracts.
    always_comb begin
        for (int unsigned a = 0; a < NREG; a++) begin
            sb_sum[a] = 32'(cnt_q[a]);
            for (int unsigned i = 0; i < N; i++) begin
                if (accept[i] && (ReqAddr[i*D +: D] == D'(a))) begin
                    sb_sum[a] = sb_sum[a] + 1;
                end
            end
            if (WriteEn && (Waddr == D'(a)) && (sb_sum[a] != 0)) begin
                sb_sum[a] = sb_sum[a] - 1;
            end
            cnt_d[a] = (sb_sum[a] > CMAX) ? CW'(CMAX) : CW'(sb_sum[a]);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned a = 0; a < NREG; a++) begin
                cnt_q[a] <= '0;
            end
        end else begin
            for (int unsigned a = 0; a < NREG; a++) begin
                cnt_q[a] <= cnt_d[a];
            end
        end
    end

    for (genvar a = 0; a < NREG; a++) begin : g_busy
        assign Busy[a] = (cnt_q[a] != '0);

        a_cnt_max: assert property (@(posedge Clk) disable iff (!Reset) sb_sum[a] <= CMAX);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, round-robin,
// full FIFO, scoreboard counting and streaming.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic [2:0]  ReqValid;
    logic [8:0]  ReqAddr;
    logic [23:0] ReqData;
    logic [2:0]  ReqReady;
    logic        WriteEn;
    logic [2:0]  Waddr;
    logic [7:0]  WData;
    logic [7:0]  Busy;
    logic        Idle;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_write_arbiter dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqAddr  (ReqAddr),
        .ReqData  (ReqData),
        .ReqReady (ReqReady),
        .WriteEn  (WriteEn),
        .Waddr    (Waddr),
        .WData    (WData),
        .Busy     (Busy),
        .Idle     (Idle)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        ReqAddr[i*3 +: 3] = a;
        ReqData[i*8 +: 8] = d;
    endtask

    initial begin
        logic [7:0] exp_busy;

        Reset    = 1'b0;
        ReqValid = '0;
        ReqAddr  = '0;
        ReqData  = '0;
        #1;
        chk("rst_ready", 32'(ReqReady), 32'h7);
        chk("rst_wen",   32'(WriteEn),  32'h0);
        chk("rst_busy",  32'(Busy),     32'h0);
        chk("rst_idle",  32'(Idle),     32'h1);
        chk("rst_waddr", 32'(Waddr),    32'h0);
        chk("rst_wdata", 32'(WData),    32'h0);
        #11;
        Reset = 1'b1;

        // Round-robin, first round starts at ALU after reset
        set_req(0, 3'd1, 8'hA1);
        set_req(1, 3'd0, 8'hB0);
        set_req(2, 3'd2, 8'hC2);
        ReqValid = 3'b111;
        tick();
        chk("rr_acc_busy", 32'(Busy),    32'h07);
        chk("rr_acc_wen",  32'(WriteEn), 32'h0);
        chk("rr_acc_idle", 32'(Idle),    32'h0);
        ReqValid = '0;
        tick();
        chk("rr1_wen",   32'(WriteEn), 32'h1);
        chk("rr1_waddr", 32'(Waddr),   32'h1);
        chk("rr1_wdata", 32'(WData),   32'hA1);
        chk("rr1_busy",  32'(Busy),    32'h07);
        tick();
        chk("rr2_waddr", 32'(Waddr),   32'h0);
        chk("rr2_wdata", 32'(WData),   32'hB0);
        chk("rr2_busy",  32'(Busy),    32'h05);
        tick();
        chk("rr3_waddr", 32'(Waddr),   32'h2);
        chk("rr3_wdata", 32'(WData),   32'hC2);
        chk("rr3_busy",  32'(Busy),    32'h04);
        set_req(0, 3'd4, 8'hD4);
        set_req(1, 3'd5, 8'hE5);
        set_req(2, 3'd6, 8'hF6);
        ReqValid = 3'b111;
        tick();
        chk("rr4_wen",  32'(WriteEn), 32'h0);
        chk("rr4_busy", 32'(Busy),    32'h70);
        ReqValid = '0;
        tick();
        chk("rr5_waddr", 32'(Waddr), 32'h4);
        chk("rr5_wdata", 32'(WData), 32'hD4);
        chk("rr5_busy",  32'(Busy),  32'h70);
        tick();
        chk("rr6_waddr", 32'(Waddr), 32'h5);
        chk("rr6_wdata", 32'(WData), 32'hE5);
        chk("rr6_busy",  32'(Busy),  32'h60);
        tick();
        chk("rr7_waddr", 32'(Waddr), 32'h6);
        chk("rr7_wdata", 32'(WData), 32'hF6);
        chk("rr7_busy",  32'(Busy),  32'h40);
        tick();
        chk("rr_end_wen",  32'(WriteEn), 32'h0);
        chk("rr_end_busy", 32'(Busy),    32'h0);
        chk("rr_end_idle", 32'(Idle),    32'h1);

        // Single ALU write
        set_req(0, 3'd5, 8'h36);
        ReqValid = 3'b001;
        tick();
        chk("sw_busy0", 32'(Busy),    32'h20);
        chk("sw_wen0",  32'(WriteEn), 32'h0);
        ReqValid = '0;
        tick();
        chk("sw_wen1",   32'(WriteEn), 32'h1);
        chk("sw_waddr1", 32'(Waddr),   32'h5);
        chk("sw_wdata1", 32'(WData),   32'h36);
        chk("sw_busy1",  32'(Busy),    32'h20);
        tick();
        chk("sw_wen2",  32'(WriteEn), 32'h0);
        chk("sw_busy2", 32'(Busy),    32'h0);
        chk("sw_idle2", 32'(Idle),    32'h1);

        // Two writes to the same register in one cycle; MEM wins (last = ALU)
        set_req(0, 3'd3, 8'h31);
        set_req(2, 3'd3, 8'h33);
        ReqValid = 3'b101;
        tick();
        chk("sb_busy0", 32'(Busy), 32'h08);
        ReqValid = '0;
        tick();
        chk("sb_wdata1", 32'(WData), 32'h33);
        chk("sb_busy1",  32'(Busy),  32'h08);
        tick();
        chk("sb_wdata2", 32'(WData), 32'h31);
        chk("sb_busy2",  32'(Busy),  32'h08);
        tick();
        chk("sb_wen3",  32'(WriteEn), 32'h0);
        chk("sb_busy3", 32'(Busy),    32'h0);

        // Reset in the middle of traffic, between clock edges
        set_req(0, 3'd7, 8'h77);
        set_req(1, 3'd6, 8'h66);
        ReqValid = 3'b011;
        tick();
        chk("mr_busy0", 32'(Busy), 32'hC0);
        ReqValid = '0;
        tick();
        chk("mr_wen1",   32'(WriteEn), 32'h1);
        chk("mr_waddr1", 32'(Waddr),   32'h6);
        chk("mr_wdata1", 32'(WData),   32'h66);
        #2;
        Reset = 1'b0;
        #1;
        chk("mr_wen",   32'(WriteEn),  32'h0);
        chk("mr_busy",  32'(Busy),     32'h0);
        chk("mr_ready", 32'(ReqReady), 32'h7);
        chk("mr_idle",  32'(Idle),     32'h1);
        chk("mr_waddr", 32'(Waddr),    32'h0);
        Reset = 1'b1;
        tick();
        chk("mr_post_wen",  32'(WriteEn), 32'h0);
        chk("mr_post_idle", 32'(Idle),    32'h1);

        // MEM FIFO fills while ALU and MOV hold the port
        set_req(0, 3'd1, 8'hA0);
        set_req(1, 3'd2, 8'hB0);
        set_req(2, 3'd7, 8'hC0);
        ReqValid = 3'b111;
        tick();
        chk("ff_ready0", 32'(ReqReady), 32'h7);
        chk("ff_busy0",  32'(Busy),     32'h86);
        ReqValid = 3'b100;
        set_req(2, 3'd7, 8'hC1);
        tick();
        chk("ff_waddr1", 32'(Waddr),    32'h1);
        chk("ff_wdata1", 32'(WData),    32'hA0);
        chk("ff_ready1", 32'(ReqReady), 32'h3);
        chk("ff_busy1",  32'(Busy),     32'h86);
        set_req(2, 3'd7, 8'hC2);
        tick();
        chk("ff_waddr2", 32'(Waddr),    32'h2);
        chk("ff_wdata2", 32'(WData),    32'hB0);
        chk("ff_ready2", 32'(ReqReady), 32'h3);
        chk("ff_busy2",  32'(Busy),     32'h84);
        ReqValid = '0;
        tick();
        chk("ff_waddr3", 32'(Waddr),    32'h7);
        chk("ff_wdata3", 32'(WData),    32'hC0);
        chk("ff_busy3",  32'(Busy),     32'h80);
        chk("ff_ready3", 32'(ReqReady), 32'h7);
        tick();
        chk("ff_wen4",   32'(WriteEn), 32'h1);
        chk("ff_wdata4", 32'(WData),   32'hC1);
        chk("ff_busy4",  32'(Busy),    32'h80);
        tick();
        chk("ff_wen5",  32'(WriteEn), 32'h0);
        chk("ff_busy5", 32'(Busy),    32'h0);
        chk("ff_idle5", 32'(Idle),    32'h1);

        // ALU streams eight writes back to back
        for (int i = 0; i < 8; i++) begin
            set_req(0, 3'(i), 8'(8'h40 + i));
            ReqValid = 3'b001;
            tick();
            exp_busy = 8'(1 << i);
            if (i > 0) begin
                exp_busy = exp_busy | 8'(1 << (i - 1));
            end
            chk("bb_busy",  32'(Busy),     32'(exp_busy));
            chk("bb_ready", 32'(ReqReady), 32'h7);
            if (i == 0) begin
                chk("bb_wen_first", 32'(WriteEn), 32'h0);
            end else begin
                chk("bb_wen",   32'(WriteEn), 32'h1);
                chk("bb_waddr", 32'(Waddr),   32'(i - 1));
                chk("bb_wdata", 32'(WData),   32'(8'h40 + i - 1));
            end
        end
        ReqValid = '0;
        tick();
        chk("bb_last_waddr", 32'(Waddr), 32'h7);
        chk("bb_last_wdata", 32'(WData), 32'h47);
        chk("bb_last_busy",  32'(Busy),  32'h80);
        tick();
        chk("bb_end_wen",  32'(WriteEn), 32'h0);
        chk("bb_end_busy", 32'(Busy),    32'h0);
        chk("bb_end_idle", 32'(Idle),    32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
